// File: rtl/hdmi_src_switch.sv
// Purpose : glitch-free HDMI source change (VGA scaler <-> FT812 DAC): frame-aligned blank, PLL retarget, FIFO flush, lock + settle, unblank.
// Latency : sel_req to WAIT_VS entry 3 clk; sel flips in the BLANK cycle; unblank the cycle after the SETTLE_FRAMES-th vsync edge.
// Backpress: none; requests arriving while busy are re-evaluated on the next RUN cycle, so only the latest request is served.
//
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   sel_req        requested source (async, 2-FF synchronized)
//   vs             vsync of current source (clk domain, active high)
//   locked         HDMI PLL lock (async, 2-FF synchronized)
//   sel            registered source select to PLL and mux
//   fifo_rst       RGB/audio FIFO reset, active high
//   force_blank    forces encoder to black
//   busy           high in any state other than RUN
//   lock_err       sticky lock-timeout flag, cleared only by reset
module hdmi_src_switch #(
  parameter bit DEFAULT_SEL     = 1'b0,
  parameter int VS_TIMEOUT      = 2000000,
  parameter int FIFO_RST_CYCLES = 8,
  parameter int LOCK_STABLE     = 16,
  parameter int LOCK_TIMEOUT    = 1048576,
  parameter int SETTLE_FRAMES   = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sel_req,
  input  logic vs,
  input  logic locked,
  output logic sel,
  output logic fifo_rst,
  output logic force_blank,
  output logic busy,
  output logic lock_err
);

  // One counter width sized for the largest limit.
  localparam int MAX_A = (VS_TIMEOUT > LOCK_TIMEOUT) ? VS_TIMEOUT : LOCK_TIMEOUT;
  localparam int MAX_B = (FIFO_RST_CYCLES > LOCK_STABLE) ? FIFO_RST_CYCLES : LOCK_STABLE;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > SETTLE_FRAMES) ? MAX_C : SETTLE_FRAMES;
  localparam int CW    = $clog2(MAX_P + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [2:0] {
    RUN,
    WAIT_VS,
    BLANK,
    FLUSH,
    WAIT_LOCK,
    SETTLE
  } state_t;

  state_t state, state_nxt;
  logic   req_meta, req_s;
  logic   lock_meta, lock_s;
  logic   vs_d, vs_rise;
  logic   target, target_nxt;
  logic   lock_to;
  cnt_t   tmo_cnt;   // WAIT_VS timeout, FLUSH length, WAIT_LOCK timeout
  cnt_t   stab_cnt;  // consecutive lock_s=1 cycles in WAIT_LOCK
  cnt_t   frm_cnt;   // vsync edges seen in SETTLE

  // Synchronizers and vsync edge detect. The request chain resets to the
  // default source so reset release never looks like a switch request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta  <= DEFAULT_SEL;
      req_s     <= DEFAULT_SEL;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      vs_d      <= 1'b0;
    end else begin
      req_meta  <= sel_req;
      req_s     <= req_meta;
      lock_meta <= locked;
      lock_s    <= lock_meta;
      vs_d      <= vs;
    end
  end

  assign vs_rise = vs & ~vs_d;

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    lock_to    = 1'b0;
    case (state)
      RUN: begin
        if (req_s != sel) begin
          target_nxt = req_s;
          state_nxt  = WAIT_VS;
        end else if (!lock_s) begin
          state_nxt = FLUSH;
        end
      end
      WAIT_VS: begin
        // Track the request until we leave, so BLANK applies the latest one.
        target_nxt = req_s;
        if (vs_rise || (tmo_cnt == cnt_t'(VS_TIMEOUT - 1)))
          state_nxt = BLANK;
      end
      BLANK: state_nxt = FLUSH;
      FLUSH: begin
        if (tmo_cnt == cnt_t'(FIFO_RST_CYCLES - 1))
          state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // This cycle's lock_s=1 brings the stable count to LOCK_STABLE.
        if (lock_s && (stab_cnt == cnt_t'(LOCK_STABLE - 1))) begin
          state_nxt = SETTLE;
        end else if (tmo_cnt == cnt_t'(LOCK_TIMEOUT - 1)) begin
          lock_to   = 1'b1;
          state_nxt = FLUSH;
        end
      end
      SETTLE: begin
        if (!lock_s)
          state_nxt = FLUSH;
        else if (vs_rise && (frm_cnt == cnt_t'(SETTLE_FRAMES - 1)))
          state_nxt = RUN;
      end
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FLUSH;
      target      <= DEFAULT_SEL;
      sel         <= DEFAULT_SEL;
      fifo_rst    <= 1'b1;
      force_blank <= 1'b1;
      busy        <= 1'b1;
      lock_err    <= 1'b0;
      tmo_cnt     <= '0;
      stab_cnt    <= '0;
      frm_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      // Outputs are decoded from the next state so they align with it.
      if (state_nxt == BLANK)
        sel <= target_nxt;
      fifo_rst    <= (state_nxt == FLUSH);
      force_blank <= (state_nxt != RUN);
      busy        <= (state_nxt != RUN);
      if (lock_to)
        lock_err <= 1'b1;

      if (state_nxt != state) begin
        tmo_cnt  <= '0;
        stab_cnt <= '0;
        frm_cnt  <= '0;
      end else begin
        if (tmo_cnt != CNT_MAX)
          tmo_cnt <= tmo_cnt + 1'b1;
        if (!lock_s)
          stab_cnt <= '0;
        else if (stab_cnt != CNT_MAX)
          stab_cnt <= stab_cnt + 1'b1;
        if (vs_rise && (frm_cnt != CNT_MAX))
          frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_src_switch.sv
// Purpose : directed bench for hdmi_src_switch (VS_TIMEOUT=100, LOCK_TIMEOUT=64, others default).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpress: n/a.
module tb_hdmi_src_switch;

  logic clk = 1'b0;
  logic reset_n, sel_req, vs, locked;
  logic sel, fifo_rst, force_blank, busy, lock_err;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hdmi_src_switch #(
    .DEFAULT_SEL    (1'b0),
    .VS_TIMEOUT     (100),
    .FIFO_RST_CYCLES(8),
    .LOCK_STABLE    (16),
    .LOCK_TIMEOUT   (64),
    .SETTLE_FRAMES  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sel_req    (sel_req),
    .vs         (vs),
    .locked     (locked),
    .sel        (sel),
    .fifo_rst   (fifo_rst),
    .force_blank(force_blank),
    .busy       (busy),
    .lock_err   (lock_err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle vsync pulse; returns at the falling edge after the detecting edge.
  task automatic vs_pulse();
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sel_req = 1'b0;
    vs      = 1'b0;
    locked  = 1'b1;
    step(2);

    // Reset state
    chk("rst_sel", sel, 1'b0);
    chk("rst_fifo_rst", fifo_rst, 1'b1);
    chk("rst_blank", force_blank, 1'b1);
    chk("rst_busy", busy, 1'b1);
    chk("rst_lock_err", lock_err, 1'b0);

    // Power-up: 8 FLUSH cycles after release, then lock and 2 frames
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("pwr_flush_hi", fifo_rst, 1'b1);
    end
    step(1);
    chk("pwr_flush_lo", fifo_rst, 1'b0);
    chk("pwr_busy", busy, 1'b1);
    step(30);
    chk("pwr_blank_wait", force_blank, 1'b1);
    vs_pulse();
    chk("pwr_blank_1frame", force_blank, 1'b1);
    step(3);
    vs_pulse();
    chk("pwr_unblank", force_blank, 1'b0);
    chk("pwr_busy_done", busy, 1'b0);
    chk("pwr_sel", sel, 1'b0);

    // Switch 0->1 aligned to a vsync edge
    sel_req = 1'b1;
    step(2);
    chk("sw1_still_run", busy, 1'b0);
    step(1);
    chk("sw1_wait_vs", busy, 1'b1);
    chk("sw1_blank", force_blank, 1'b1);
    chk("sw1_sel_old", sel, 1'b0);
    step(5);
    chk("sw1_sel_hold", sel, 1'b0);
    vs_pulse();
    chk("sw1_sel_new", sel, 1'b1);
    chk("sw1_blank_cyc_fifo", fifo_rst, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("sw1_flush_hi", fifo_rst, 1'b1);
    end
    step(1);
    chk("sw1_flush_lo", fifo_rst, 1'b0);
    step(20);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("sw1_unblank", force_blank, 1'b0);
    chk("sw1_sel_final", sel, 1'b1);
    chk("sw1_lock_err", lock_err, 1'b0);

    // Switch 1->0 with vsync held low: BLANK exactly 100 cycles after WAIT_VS entry
    sel_req = 1'b0;
    step(3);
    chk("to_wait_vs", busy, 1'b1);
    step(99);
    chk("to_sel_before", sel, 1'b1);
    step(1);
    chk("to_sel_after", sel, 1'b0);
    step(1);
    chk("to_flush", fifo_rst, 1'b1);
    step(30);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("to_run", busy, 1'b0);
    chk("to_sel_final", sel, 1'b0);

    // Lock held low: lock-loss flush, timeout every 64+8 cycles, then recovery
    locked = 1'b0;
    step(2);
    chk("lt_run_sync", fifo_rst, 1'b0);
    step(1);
    chk("lt_flush1", fifo_rst, 1'b1);
    chk("lt_blank", force_blank, 1'b1);
    step(8);
    chk("lt_wait_lock", fifo_rst, 1'b0);
    step(63);
    chk("lt_before_to", fifo_rst, 1'b0);
    chk("lt_err_before", lock_err, 1'b0);
    step(1);
    chk("lt_flush2", fifo_rst, 1'b1);
    chk("lt_err_set", lock_err, 1'b1);
    step(71);
    chk("lt_before_to2", fifo_rst, 1'b0);
    step(1);
    chk("lt_flush3", fifo_rst, 1'b1);
    locked = 1'b1;
    step(45);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("lt_run", busy, 1'b0);
    chk("lt_sel_kept", sel, 1'b0);
    chk("lt_err_sticky", lock_err, 1'b1);

    // Lock glitch of 3 cycles during RUN
    locked = 1'b0;
    step(3);
    chk("lg_flush", fifo_rst, 1'b1);
    chk("lg_blank", force_blank, 1'b1);
    locked = 1'b1;
    step(45);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("lg_run", force_blank, 1'b0);
    chk("lg_sel_kept", sel, 1'b0);

    // Switch to 1, request back to 0 during SETTLE: second switch follows RUN
    sel_req = 1'b1;
    step(3);
    vs_pulse();
    chk("rb_sel1", sel, 1'b1);
    step(30);
    sel_req = 1'b0;
    step(5);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("rb_run_one_cycle", busy, 1'b0);
    chk("rb_sel_still1", sel, 1'b1);
    step(1);
    chk("rb_second_switch", busy, 1'b1);
    step(3);
    vs_pulse();
    chk("rb_sel0", sel, 1'b0);
    // Request toggling back to the current source before RUN: no extra switch
    step(30);
    sel_req = 1'b1;
    step(5);
    sel_req = 1'b0;
    step(5);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("nx_run", busy, 1'b0);
    step(6);
    chk("nx_no_switch", busy, 1'b0);
    chk("nx_sel", sel, 1'b0);

    // Reset asserted mid-FLUSH after switching to 1
    sel_req = 1'b1;
    step(3);
    vs_pulse();
    step(2);
    chk("mr_in_flush", fifo_rst, 1'b1);
    chk("mr_sel1", sel, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_sel_default", sel, 1'b0);
    chk("mr_lock_err_clr", lock_err, 1'b0);
    chk("mr_busy", busy, 1'b1);
    sel_req = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("mr_restart_flush", fifo_rst, 1'b1);
    step(30);
    vs_pulse();
    step(3);
    vs_pulse();
    chk("mr_run", busy, 1'b0);
    chk("mr_sel_final", sel, 1'b0);
    chk("mr_lock_err_final", lock_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdmi_src_switch.md
# hdmi_src_switch

Sequencer for the HDMI output path that changes the active video source (VGA scaler vs. FT812 video DAC) without glitches. It waits for a frame boundary, blanks the output, retargets the HDMI PLL and flushes the clock-crossing FIFOs. It then waits for a stable PLL lock and a settle period before unblanking. It sits between the register that holds the source-select bit and the HDMI PLL, FIFO and mux stage, and drives their select, reset and blank controls.

## Interface
- `DEFAULT_SEL`, 0: source selected after reset (0 = VGA, 1 = FT).
- `VS_TIMEOUT`, 2000000: cycles to wait for a vsync edge before switching anyway.
- `FIFO_RST_CYCLES`, 8: cycles `fifo_rst` is held high per flush.
- `LOCK_STABLE`, 16: consecutive cycles `locked` must be high to count as locked.
- `LOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_LOCK before a retry.
- `SETTLE_FRAMES`, 2: vsync rising edges to wait after lock before unblanking.

Ports:
- `clk`  in  1  system clock; all logic is in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sel_req`  in  1  requested source, asynchronous; synchronized internally by a 2-FF chain.
- `vs`  in  1  vsync of the currently selected source, already in the `clk` domain, active high.
- `locked`  in  1  HDMI PLL lock, asynchronous; synchronized internally by a 2-FF chain.
- `sel`  out  1  registered source select to the PLL and the mux.
- `fifo_rst`  out  1  reset to the RGB and audio FIFOs, active high.
- `force_blank`  out  1  forces the HDMI encoder blank/black.
- `busy`  out  1  high in any state other than RUN.
- `lock_err`  out  1  sticky flag, set on any lock timeout.

## Operation
- States: RUN, WAIT_VS, BLANK, FLUSH, WAIT_LOCK, SETTLE.
- Reset values: state=FLUSH, `sel`=DEFAULT_SEL, `fifo_rst`=1, `force_blank`=1, `busy`=1, `lock_err`=0, all counters 0.
- RUN:
  - If `req_s` != `sel`, latch `target`=`req_s` and go to WAIT_VS.
  - Else if `lock_s`=0, go to FLUSH. `target` keeps the value of `sel`.
- WAIT_VS: go to BLANK on a `vs` rising edge, or when the timeout counter reaches VS_TIMEOUT-1.
- BLANK: one cycle. `force_blank`=1, `sel`<=`target`. Go to FLUSH.
- FLUSH: `fifo_rst`=1 for FIFO_RST_CYCLES cycles. Go to WAIT_LOCK.
- WAIT_LOCK:
  - The stable counter counts while `lock_s`=1 and clears to 0 whenever `lock_s`=0.
  - When the stable counter reaches LOCK_STABLE, go to SETTLE.
  - When the timeout counter reaches LOCK_TIMEOUT-1, set `lock_err` and go to FLUSH (retry, no limit on retries).
- SETTLE:
  - Count `vs` rising edges. After SETTLE_FRAMES edges, go to RUN.
  - If `lock_s` falls, go to FLUSH.
- Outputs by state:
  - `force_blank`=1 in every state except RUN.
  - `fifo_rst`=1 only in FLUSH.
  - `busy` = (state != RUN).
- `vs` edge detection compares `vs` with its value one cycle earlier, registered.
- Requests arriving while busy: `target` is frozen from WAIT_VS exit. A later `sel_req` change is served when the FSM next reaches RUN. A request that toggles back to the current `sel` before RUN causes no extra switch.
- Counter widths: $clog2(max parameter + 1). Counters saturate and never wrap. Each counter clears on state entry.
- `lock_err` clears only on reset.

## Timing
- `sel_req` to WAIT_VS entry: 3 cycles (2 sync stages + 1 compare).
- `locked` sync latency: 2 cycles.
- `sel` changes exactly once per switch, in the BLANK cycle. `force_blank` is already 1 from the preceding WAIT_VS cycle.
- `fifo_rst` rises the cycle after BLANK and stays high for exactly FIFO_RST_CYCLES cycles.
- `force_blank` falls in the first RUN cycle, which is the cycle after the SETTLE_FRAMES-th `vs` edge is detected.
- Reset mid-operation: all outputs return to their reset values asynchronously. Reset release restarts the sequence from FLUSH.
- Simultaneous `vs` edge and timeout in WAIT_VS: go to BLANK once.

## Test plan
- Power-up, `locked`=1 from start, `vs` period 1000 cycles, default parameters → `fifo_rst` high for the reset cycle plus 8 cycles; `force_blank` falls after the 2nd `vs` edge; `busy`=0; `sel`=0.
- In RUN, toggle `sel_req` 0→1 → WAIT_VS; `sel` goes to 1 on the cycle after the next `vs` edge; `fifo_rst` pulses 8 cycles; unblank after 2 frames; `lock_err`=0.
- Switch with `vs` held low, VS_TIMEOUT=100 → BLANK entered exactly 100 cycles after WAIT_VS entry.
- `locked` held low, LOCK_TIMEOUT=64 → `lock_err`=1; FLUSH repeats every 64+8 cycles; raising `locked` completes the switch, and `lock_err` stays 1.
- `locked` drops for 3 cycles during RUN → `force_blank`=1, `fifo_rst` pulse, then WAIT_LOCK→SETTLE→RUN; `sel` unchanged.
- `sel_req` toggles 0→1→0 during SETTLE → after RUN, a second switch back to `sel`=0 follows. Assert `reset_n` low mid-FLUSH → `sel`=DEFAULT_SEL and `lock_err`=0 immediately.
